// File: rtl/tag_pool_if.sv
// Command-side bus of the tag pool: allocation, release, flush and pool status.
// The master drives requests and the slave (the pool) returns grants and payloads.
interface tag_pool_if #(
  parameter int TAG_W     = 8,
  parameter int PAYLOAD_W = 256
);
  logic                 flush_in;
  logic                 alloc_req_in;
  logic [PAYLOAD_W-1:0] alloc_payload_in;
  logic                 alloc_grant_out;
  logic [TAG_W-1:0]     alloc_tag_out;
  logic                 release_valid_in;
  logic [TAG_W-1:0]     release_tag_in;
  logic                 release_valid_out;
  logic [TAG_W-1:0]     release_tag_out;
  logic [PAYLOAD_W-1:0] release_payload_out;
  logic [TAG_W:0]       free_count_out;
  logic                 ready_out;
  logic                 error_out;

  modport master (
    output flush_in, alloc_req_in, alloc_payload_in, release_valid_in, release_tag_in,
    input  alloc_grant_out, alloc_tag_out, release_valid_out, release_tag_out,
    input  release_payload_out, free_count_out, ready_out, error_out
  );

  modport slave (
    input  flush_in, alloc_req_in, alloc_payload_in, release_valid_in, release_tag_in,
    output alloc_grant_out, alloc_tag_out, release_valid_out, release_tag_out,
    output release_payload_out, free_count_out, ready_out, error_out
  );
endinterface

// File: rtl/tag_pool_control.sv
// Command tag allocator: free-list FIFO of tags plus per-tag payload RAM.
// Define TAG_POOL_CHECK_EN to add the in-flight bitmap and sticky release error.
//
// state          | meaning
// TAG_POOL_RESET | held in reset, all outputs 0
// TAG_POOL_INIT  | pushing tags 0..NUM_TAGS-1 into the free list, one per cycle
// TAG_POOL_READY | accepting allocations and releases
module tag_pool_control #(
  parameter int NUM_TAGS  = 32,
  parameter int TAG_W     = 8,
  parameter int PAYLOAD_W = 256
) (
  input  logic         clock,
  input  logic         rstn,
  tag_pool_if.slave    bus
);
  localparam int PTR_W = $clog2(NUM_TAGS);
  localparam logic [TAG_W:0]     LP_NUM      = (TAG_W+1)'(NUM_TAGS);
  localparam logic [TAG_W-1:0]   LP_TAG_LAST = TAG_W'(NUM_TAGS - 1);
  localparam logic [PTR_W-1:0]   LP_PTR_LAST = PTR_W'(NUM_TAGS - 1);

  typedef enum logic [1:0] {TAG_POOL_RESET, TAG_POOL_INIT, TAG_POOL_READY} state_t;
  state_t r_state, w_state_nxt;

  logic [TAG_W-1:0]     r_fifo [NUM_TAGS];
  logic [PAYLOAD_W-1:0] r_ram  [NUM_TAGS];
  logic [PTR_W-1:0]     r_head, r_tail;
  logic [TAG_W:0]       r_count;
  logic [TAG_W-1:0]     r_init_tag;
  logic                 r_grant, r_rel_valid;
  logic [TAG_W-1:0]     r_alloc_tag, r_rel_tag;
  logic [PAYLOAD_W-1:0] r_rel_payload;

  logic             w_ready, w_init_push, w_grant, w_rel_acc, w_push, w_tag_live;
  logic [TAG_W-1:0] w_alloc_tag, w_push_tag;
  logic [PTR_W-1:0] w_alloc_idx, w_rel_idx;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == LP_PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) r_state <= TAG_POOL_RESET;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush_in) begin
      w_state_nxt = TAG_POOL_INIT;
    end else begin
      case (r_state)
        TAG_POOL_RESET: w_state_nxt = TAG_POOL_INIT;
        TAG_POOL_INIT:  if (r_init_tag == LP_TAG_LAST) w_state_nxt = TAG_POOL_READY;
        TAG_POOL_READY: w_state_nxt = TAG_POOL_READY;
        default:        w_state_nxt = TAG_POOL_RESET;
      endcase
    end
  end

  assign w_ready     = (r_state == TAG_POOL_READY);
  assign w_init_push = (r_state == TAG_POOL_INIT) && !bus.flush_in;
  assign w_alloc_tag = r_fifo[r_head];
  assign w_alloc_idx = w_alloc_tag[PTR_W-1:0];
  assign w_rel_idx   = bus.release_tag_in[PTR_W-1:0];
  // No bypass: a release this cycle cannot satisfy an alloc on an empty pool.
  assign w_grant     = w_ready && !bus.flush_in && bus.alloc_req_in && (r_count != '0);
  assign w_rel_acc   = w_ready && !bus.flush_in && bus.release_valid_in &&
                       ({1'b0, bus.release_tag_in} < LP_NUM) && (r_count < LP_NUM) && w_tag_live;
  assign w_push      = w_init_push || w_rel_acc;
  assign w_push_tag  = w_init_push ? r_init_tag : bus.release_tag_in;

`ifdef TAG_POOL_CHECK_EN
  logic [NUM_TAGS-1:0] r_inflight, w_set_mask, w_clr_mask;
  logic                r_error, w_rel_err;

  assign w_tag_live = r_inflight[w_rel_idx] && !(w_grant && (w_alloc_idx == w_rel_idx));
  assign w_rel_err  = w_ready && !bus.flush_in && bus.release_valid_in && !w_rel_acc;
  assign w_set_mask = w_grant   ? ({{(NUM_TAGS-1){1'b0}}, 1'b1} << w_alloc_idx) : '0;
  assign w_clr_mask = w_rel_acc ? ({{(NUM_TAGS-1){1'b0}}, 1'b1} << w_rel_idx)   : '0;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_inflight <= '0;
      r_error    <= 1'b0;
    end else if (bus.flush_in) begin
      r_inflight <= '0;
      r_error    <= 1'b0;
    end else begin
      r_inflight <= (r_inflight | w_set_mask) & ~w_clr_mask;
      if (w_rel_err) r_error <= 1'b1;
    end
  end

  assign bus.error_out = r_error;
`else
  assign w_tag_live    = 1'b1;
  assign bus.error_out = 1'b0;
`endif

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_init_tag    <= '0;
      r_grant       <= 1'b0;
      r_alloc_tag   <= '0;
      r_rel_valid   <= 1'b0;
      r_rel_tag     <= '0;
      r_rel_payload <= '0;
    end else if (bus.flush_in) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_init_tag    <= '0;
      r_grant       <= 1'b0;
      r_alloc_tag   <= '0;
      r_rel_valid   <= 1'b0;
      r_rel_tag     <= '0;
      r_rel_payload <= '0;
    end else begin
      r_grant       <= w_grant;
      r_alloc_tag   <= w_grant ? w_alloc_tag : '0;
      r_rel_valid   <= w_rel_acc;
      r_rel_tag     <= w_rel_acc ? bus.release_tag_in : '0;
      r_rel_payload <= w_rel_acc ? r_ram[w_rel_idx] : '0;
      if (w_init_push) r_init_tag <= r_init_tag + TAG_W'(1);
      if (w_push)      r_tail     <= f_next(r_tail);
      if (w_grant)     r_head     <= f_next(r_head);
      case ({w_push, w_grant})
        2'b10:   r_count <= r_count + (TAG_W+1)'(1);
        2'b01:   r_count <= r_count - (TAG_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage arrays are not reset; entries are always written before being read.
  always_ff @(posedge clock) begin
    if (w_push)  r_fifo[r_tail]     <= w_push_tag;
    if (w_grant) r_ram[w_alloc_idx] <= bus.alloc_payload_in;
  end

  assign bus.alloc_grant_out     = r_grant;
  assign bus.alloc_tag_out       = r_alloc_tag;
  assign bus.release_valid_out   = r_rel_valid;
  assign bus.release_tag_out     = r_rel_tag;
  assign bus.release_payload_out = r_rel_payload;
  assign bus.free_count_out      = r_count;
  assign bus.ready_out           = w_ready;
endmodule

// File: tb/tb_tag_pool_control.sv
// Directed bench for tag_pool_control: a 32-tag pool and a 3-tag pool sharing clock and reset.
// Error expectations follow TAG_POOL_CHECK_EN when the bench is built with it.
module tb_tag_pool_control;
  logic clock = 1'b0;
  logic rstn  = 1'b0;
  int vectors = 0;
  int miscompares = 0;

`ifdef TAG_POOL_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  tag_pool_if #(.TAG_W(8), .PAYLOAD_W(256)) bus  ();
  tag_pool_if #(.TAG_W(8), .PAYLOAD_W(8))   bus3 ();

  tag_pool_control #(.NUM_TAGS(32), .TAG_W(8), .PAYLOAD_W(256)) u_dut (
    .clock(clock), .rstn(rstn), .bus(bus.slave));
  tag_pool_control #(.NUM_TAGS(3), .TAG_W(8), .PAYLOAD_W(8)) u_dut3 (
    .clock(clock), .rstn(rstn), .bus(bus3.slave));

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    bus.flush_in = 0; bus.alloc_req_in = 0; bus.alloc_payload_in = '0;
    bus.release_valid_in = 0; bus.release_tag_in = '0;
    bus3.flush_in = 0; bus3.alloc_req_in = 0; bus3.alloc_payload_in = '0;
    bus3.release_valid_in = 0; bus3.release_tag_in = '0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.ready_out && n < 100) begin tick(); n++; end
    vectors++;
    if (n !== 32) begin
      miscompares++;
      $display("FAIL %s_cycles: got %0d cycles want 32", name, n);
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    #12;
    vectors++;
    if ({bus.alloc_grant_out, bus.release_valid_out, bus.ready_out, bus.error_out} !== 4'b0 ||
        bus.free_count_out !== 9'd0 || bus.alloc_tag_out !== 8'd0 || bus.release_payload_out !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ready=%0b cnt=%0d grant=%0b want all 0",
               bus.ready_out, bus.free_count_out, bus.alloc_grant_out);
    end
    rstn = 1'b1;
    tick();
    wait_ready("init");
    vectors++;
    if (bus.free_count_out !== 9'd32) begin
      miscompares++;
      $display("FAIL init_count: got %0d want 32", bus.free_count_out);
    end
  endtask

  task automatic test_alloc_all;
    bus.alloc_req_in = 1;
    for (int i = 0; i < 32; i++) begin
      bus.alloc_payload_in = (i == 5) ? {32{8'hA5}} : {32{8'(i)}};
      tick();
      vectors++;
      if (bus.alloc_grant_out !== 1'b1 || bus.alloc_tag_out !== 8'(i)) begin
        miscompares++;
        $display("FAIL alloc_seq[%0d]: got grant=%0b tag=%0d want grant=1 tag=%0d",
                 i, bus.alloc_grant_out, bus.alloc_tag_out, i);
      end
    end
    vectors++;
    if (bus.free_count_out !== 9'd0) begin
      miscompares++;
      $display("FAIL alloc_drained_count: got %0d want 0", bus.free_count_out);
    end
    tick();
    vectors++;
    if (bus.alloc_grant_out !== 1'b0) begin
      miscompares++;
      $display("FAIL alloc_empty_grant: got %0b want 0", bus.alloc_grant_out);
    end
    bus.alloc_req_in = 0;
  endtask

  task automatic test_release_payload;
    logic [255:0] exp_pl = {32{8'hA5}};
    bus.release_valid_in = 1; bus.release_tag_in = 8'd5;
    tick();
    bus.release_valid_in = 0;
    vectors++;
    if (bus.release_valid_out !== 1'b1 || bus.release_tag_out !== 8'd5 ||
        bus.release_payload_out !== exp_pl) begin
      miscompares++;
      $display("FAIL release5: got v=%0b tag=%0d pl=%h want v=1 tag=5 pl=%h",
               bus.release_valid_out, bus.release_tag_out, bus.release_payload_out, exp_pl);
    end
    vectors++;
    if (bus.free_count_out !== 9'd1) begin
      miscompares++;
      $display("FAIL release5_count: got %0d want 1", bus.free_count_out);
    end
    bus.alloc_req_in = 1;
    tick();
    bus.alloc_req_in = 0;
    vectors++;
    if (bus.alloc_grant_out !== 1'b1 || bus.alloc_tag_out !== 8'd5) begin
      miscompares++;
      $display("FAIL realloc5: got grant=%0b tag=%0d want grant=1 tag=5",
               bus.alloc_grant_out, bus.alloc_tag_out);
    end
  endtask

  task automatic test_same_cycle;
    bus.alloc_req_in = 1; bus.release_valid_in = 1; bus.release_tag_in = 8'd3;
    tick();
    bus.release_valid_in = 0;
    vectors++;
    if (bus.alloc_grant_out !== 1'b0 || bus.release_valid_out !== 1'b1 || bus.release_tag_out !== 8'd3) begin
      miscompares++;
      $display("FAIL same_cycle_nobypass: got grant=%0b relv=%0b reltag=%0d want 0 1 3",
               bus.alloc_grant_out, bus.release_valid_out, bus.release_tag_out);
    end
    tick();
    bus.alloc_req_in = 0;
    vectors++;
    if (bus.alloc_grant_out !== 1'b1 || bus.alloc_tag_out !== 8'd3 || bus.free_count_out !== 9'd0) begin
      miscompares++;
      $display("FAIL same_cycle_regrant: got grant=%0b tag=%0d cnt=%0d want 1 3 0",
               bus.alloc_grant_out, bus.alloc_tag_out, bus.free_count_out);
    end
  endtask

  task automatic test_flush;
    bus.release_valid_in = 1;
    for (int t = 0; t < 22; t++) begin
      bus.release_tag_in = 8'(t);
      tick();
    end
    bus.release_valid_in = 0;
    vectors++;
    if (bus.free_count_out !== 9'd22) begin
      miscompares++;
      $display("FAIL flush_pre_count: got %0d want 22", bus.free_count_out);
    end
    bus.flush_in = 1; bus.alloc_req_in = 1;
    tick();
    bus.flush_in = 0; bus.alloc_req_in = 0;
    vectors++;
    if (bus.ready_out !== 1'b0 || bus.free_count_out !== 9'd0 || bus.alloc_grant_out !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_outputs: got ready=%0b cnt=%0d grant=%0b want 0 0 0",
               bus.ready_out, bus.free_count_out, bus.alloc_grant_out);
    end
    wait_ready("flush");
    vectors++;
    if (bus.free_count_out !== 9'd32) begin
      miscompares++;
      $display("FAIL flush_count: got %0d want 32", bus.free_count_out);
    end
    bus.alloc_req_in = 1;
    tick();
    bus.alloc_req_in = 0;
    vectors++;
    if (bus.alloc_grant_out !== 1'b1 || bus.alloc_tag_out !== 8'd0) begin
      miscompares++;
      $display("FAIL flush_first_tag: got grant=%0b tag=%0d want 1 0",
               bus.alloc_grant_out, bus.alloc_tag_out);
    end
    bus.release_valid_in = 1; bus.release_tag_in = 8'd0;
    tick();
    bus.release_valid_in = 0;
  endtask

  task automatic test_bad_release;
    logic [7:0] bad [2] = '{8'd7, 8'd40};
    for (int k = 0; k < 2; k++) begin
      bus.release_valid_in = 1; bus.release_tag_in = bad[k];
      tick();
      bus.release_valid_in = 0;
      vectors++;
      if (bus.release_valid_out !== 1'b0 || bus.free_count_out !== 9'd32 || bus.error_out !== CHECK) begin
        miscompares++;
        $display("FAIL bad_release[%0d]: got v=%0b cnt=%0d err=%0b want 0 32 %0b",
                 bad[k], bus.release_valid_out, bus.free_count_out, bus.error_out, CHECK);
      end
    end
    tick();
    vectors++;
    if (bus.error_out !== CHECK) begin
      miscompares++;
      $display("FAIL error_sticky: got %0b want %0b", bus.error_out, CHECK);
    end
    bus.flush_in = 1;
    tick();
    bus.flush_in = 0;
    vectors++;
    if (bus.error_out !== 1'b0) begin
      miscompares++;
      $display("FAIL error_flush_clear: got %0b want 0", bus.error_out);
    end
    wait_ready("bad_flush");
  endtask

  task automatic test_small_pool;
    int free_q[$];
    bit infl[3];
    free_q = '{0, 1, 2};
    infl = '{0, 0, 0};
    vectors++;
    if (bus3.ready_out !== 1'b1 || bus3.free_count_out !== 9'd3) begin
      miscompares++;
      $display("FAIL small_ready: got ready=%0b cnt=%0d want 1 3", bus3.ready_out, bus3.free_count_out);
    end
    for (int c = 0; c < 50; c++) begin
      int cand[$];
      bit req, rel, exp_g;
      int rtag, exp_t, nin;
      req = 1'($urandom_range(0, 1));
      for (int t = 0; t < 3; t++) if (infl[t]) cand.push_back(t);
      rel = (cand.size() > 0) && ($urandom_range(0, 1) == 1);
      rtag = rel ? cand[$urandom_range(0, cand.size() - 1)] : 0;
      exp_g = req && (free_q.size() > 0);
      exp_t = exp_g ? free_q[0] : 0;
      bus3.alloc_req_in = req; bus3.alloc_payload_in = 8'(c);
      bus3.release_valid_in = rel; bus3.release_tag_in = 8'(rtag);
      tick();
      if (exp_g) begin infl[exp_t] = 1; void'(free_q.pop_front()); end
      if (rel)   begin infl[rtag] = 0; free_q.push_back(rtag); end
      nin = 0;
      for (int t = 0; t < 3; t++) nin += int'(infl[t]);
      vectors++;
      if (bus3.alloc_grant_out !== exp_g || (exp_g && bus3.alloc_tag_out !== 8'(exp_t)) ||
          bus3.release_valid_out !== rel || bus3.free_count_out !== 9'(3 - nin)) begin
        miscompares++;
        $display("FAIL small_cycle[%0d]: got g=%0b tag=%0d rv=%0b cnt=%0d want g=%0b tag=%0d rv=%0b cnt=%0d",
                 c, bus3.alloc_grant_out, bus3.alloc_tag_out, bus3.release_valid_out,
                 bus3.free_count_out, exp_g, exp_t, rel, 3 - nin);
      end
    end
    bus3.alloc_req_in = 0; bus3.release_valid_in = 0;
  endtask

  initial begin
    test_reset();
    test_alloc_all();
    test_release_payload();
    test_same_cycle();
    test_flush();
    test_bad_release();
    test_small_pool();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
